// File: rtl/controle_botoes.sv
// Pushbutton front end for the 7-segment display board: synchronises and debounces the three
// buttons, keeps the power/action/speed state and drives the digit-multiplex select.
module controle_botoes #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_DIV        = 50000,
  parameter int ACT_COUNT       = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_onoff,
  input  logic btn_act,
  input  logic btn_spd,
  output logic onoff,
  output logic A_act,
  output logic B_act,
  output logic C_act,
  output logic A_spd,
  output logic B_spd,
  output logic scan_sel,
  output logic press_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SW = $clog2(SCAN_DIV) + 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [2:0]    ACT_LAST  = 3'(ACT_COUNT - 1);

  // Bit 0 = power, bit 1 = action, bit 2 = speed; all levels are active-low.
  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    stable;
  logic [2:0]    fall;
  logic [CW-1:0] cnt [3];

  logic [2:0]    act;
  logic [2:0]    act_next;
  logic [1:0]    spd;
  logic [1:0]    spd_next;
  logic          onoff_next;
  logic          evt_next;
  logic [SW-1:0] scan_cnt;

  assign raw = {btn_spd, btn_act, btn_onoff};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1     <= '1;
      s2     <= '1;
      stable <= '1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press is recognised in the same cycle the debounced level is about to drop,
  // so the state registers update on the very edge the stable level changes.
  always_comb begin
    fall = '0;
    for (int i = 0; i < 3; i++) begin
      fall[i] = stable[i] & ~s2[i] & (cnt[i] == DB_LAST);
    end
  end

  always_comb begin
    onoff_next = onoff;
    act_next   = act;
    spd_next   = spd;
    evt_next   = |fall;
    if (fall[0]) begin
      onoff_next = ~onoff;
      act_next   = '0;
      spd_next   = '0;
    end else if (onoff) begin
      if (fall[1]) act_next = (act == ACT_LAST) ? 3'd0 : act + 3'd1;
      if (fall[2]) spd_next = spd + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      onoff     <= 1'b0;
      act       <= '0;
      spd       <= '0;
      press_evt <= 1'b0;
    end else begin
      onoff     <= onoff_next;
      act       <= act_next;
      spd       <= spd_next;
      press_evt <= evt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      scan_sel <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_sel <= ~scan_sel;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign {A_act, B_act, C_act} = act;
  assign {A_spd, B_spd}        = spd;

endmodule

// File: tb/tb_controle_botoes.sv
// Self-checking bench for controle_botoes: directed scenarios plus random button traffic
// compared every cycle against a sliding-window reference model.
module tb_controle_botoes;

  localparam int DB   = 4;
  localparam int SCAN = 3;
  localparam int ACTN = 5;

  logic clk;
  logic reset_n;
  logic btn_onoff;
  logic btn_act;
  logic btn_spd;
  logic onoff;
  logic A_act;
  logic B_act;
  logic C_act;
  logic A_spd;
  logic B_spd;
  logic scan_sel;
  logic press_evt;

  int check_count = 0;
  int fail_count  = 0;
  int evt_count   = 0;

  controle_botoes #(
    .DEBOUNCE_CYCLES(DB),
    .SCAN_DIV(SCAN),
    .ACT_COUNT(ACTN)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_onoff(btn_onoff),
    .btn_act(btn_act),
    .btn_spd(btn_spd),
    .onoff(onoff),
    .A_act(A_act),
    .B_act(B_act),
    .C_act(C_act),
    .A_spd(A_spd),
    .B_spd(B_spd),
    .scan_sel(scan_sel),
    .press_evt(press_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] dut_act;
  logic [1:0] dut_spd;
  logic [7:0] dut_vec;
  assign dut_act = {A_act, B_act, C_act};
  assign dut_spd = {A_spd, B_spd};
  assign dut_vec = {onoff, dut_act, dut_spd, scan_sel, press_evt};

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: a button level is accepted once the synchronised input (raw delayed
  // by two edges) has disagreed with the accepted level for DB consecutive edges.
  int m_hist [3][DB+1];
  int m_stable [3];
  int m_on, m_act, m_spd, m_evt, m_edges;

  initial begin
    for (int b = 0; b < 3; b++) begin
      m_stable[b] = 1;
      for (int k = 0; k <= DB; k++) m_hist[b][k] = 1;
    end
    m_on = 0; m_act = 0; m_spd = 0; m_evt = 0; m_edges = 0;
  end

  always @(posedge clk) begin
    int raw_now [3];
    int fell [3];
    int all_diff;
    raw_now[0] = int'(btn_onoff);
    raw_now[1] = int'(btn_act);
    raw_now[2] = int'(btn_spd);
    if (!reset_n) begin
      for (int b = 0; b < 3; b++) begin
        m_stable[b] = 1;
        for (int k = 0; k <= DB; k++) m_hist[b][k] = 1;
      end
      m_on = 0; m_act = 0; m_spd = 0; m_evt = 0; m_edges = 0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        fell[b] = 0;
        all_diff = 1;
        for (int k = 1; k <= DB; k++) if (m_hist[b][k] == m_stable[b]) all_diff = 0;
        if (all_diff == 1) begin
          if (m_stable[b] == 1) fell[b] = 1;
          m_stable[b] = 1 - m_stable[b];
        end
      end
      m_evt = (fell[0] + fell[1] + fell[2]) > 0 ? 1 : 0;
      if (fell[0] == 1) begin
        if (m_on == 1) begin
          m_on = 0; m_act = 0; m_spd = 0;
        end else begin
          m_on = 1;
        end
      end else if (m_on == 1) begin
        if (fell[1] == 1) m_act = (m_act + 1) % ACTN;
        if (fell[2] == 1) m_spd = (m_spd + 1) % 4;
      end
      m_edges++;
      for (int b = 0; b < 3; b++) begin
        for (int k = DB; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = raw_now[b];
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_vec;
    exp_vec = {m_on[0], m_act[2:0], m_spd[1:0], 1'(((m_edges / SCAN) % 2)), m_evt[0]};
    checkOutput("model", dut_vec, exp_vec);
  end

  task automatic tick();
    @(negedge clk);
    if (press_evt === 1'b1) evt_count++;
  endtask

  // Drives the masked buttons low for low_cycles, releases everything, then idles gap_cycles.
  task automatic applyStimulus(input logic [2:0] mask, input int low_cycles, input int gap_cycles);
    if (mask[0]) btn_onoff = 1'b0;
    if (mask[1]) btn_act   = 1'b0;
    if (mask[2]) btn_spd   = 1'b0;
    repeat (low_cycles) tick();
    btn_onoff = 1'b1;
    btn_act   = 1'b1;
    btn_spd   = 1'b1;
    repeat (gap_cycles) tick();
  endtask

  int scan_exp [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  int act_seq  [6]  = '{1, 2, 3, 4, 0, 1};
  int spd_seq  [5]  = '{1, 2, 3, 0, 1};

  initial begin
    int evt_before;
    int left [3];
    logic lvl [3];

    reset_n = 1'b0; btn_onoff = 1'b0; btn_act = 1'b0; btn_spd = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outputs", dut_vec, 8'h00);
    reset_n = 1'b1; btn_onoff = 1'b1; btn_act = 1'b1; btn_spd = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput("scan_after_reset", {7'b0, scan_sel}, 8'(scan_exp[k]));
    end

    btn_onoff = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) checkOutput("power_on_early", {7'b0, onoff}, 8'h00);
      if (k == 6) checkOutput("power_on_edge", {6'b0, onoff, press_evt}, 8'h03);
      if (k == 7) checkOutput("power_on_pulse", {7'b0, press_evt}, 8'h00);
    end
    btn_onoff = 1'b1;
    evt_before = evt_count;
    repeat (10) tick();
    checkOutput("release_no_evt", 8'(evt_count - evt_before), 8'h00);
    checkOutput("still_on", {7'b0, onoff}, 8'h01);

    for (int p = 0; p < 6; p++) begin
      applyStimulus(3'b010, 8, 8);
      checkOutput("act_wrap", {5'b0, dut_act}, 8'(act_seq[p]));
    end
    for (int p = 0; p < 5; p++) begin
      applyStimulus(3'b100, 8, 8);
      checkOutput("spd_wrap", {6'b0, dut_spd}, 8'(spd_seq[p]));
    end
    applyStimulus(3'b010, 8, 8);
    applyStimulus(3'b010, 8, 8);
    applyStimulus(3'b100, 8, 8);
    checkOutput("act3_spd2", {3'b0, dut_act, dut_spd}, 8'h0E);

    evt_before = evt_count;
    repeat (5) applyStimulus(3'b010, 3, 3);
    checkOutput("glitch_evt", 8'(evt_count - evt_before), 8'h00);
    checkOutput("glitch_act", {5'b0, dut_act}, 8'h03);

    evt_before = evt_count;
    applyStimulus(3'b011, 8, 8);
    checkOutput("prio_state", {2'b0, onoff, dut_act, dut_spd}, 8'h00);
    checkOutput("prio_evt", 8'(evt_count - evt_before), 8'h01);
    evt_before = evt_count;
    applyStimulus(3'b010, 8, 8);
    checkOutput("off_act_state", {2'b0, onoff, dut_act, dut_spd}, 8'h00);
    checkOutput("off_act_evt", 8'(evt_count - evt_before), 8'h01);

    btn_spd = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) checkOutput("mid_reset_early", {7'b0, press_evt}, 8'h00);
      if (k == 6) checkOutput("mid_reset_accept", {7'b0, press_evt}, 8'h01);
    end
    checkOutput("mid_reset_spd", {6'b0, dut_spd}, 8'h00);
    btn_spd = 1'b1;
    repeat (8) tick();

    for (int b = 0; b < 3; b++) begin
      left[b] = 0;
      lvl[b]  = 1'b1;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 3; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          left[b] = int'($urandom_range(1, 9));
        end
        left[b]--;
      end
      btn_onoff = lvl[0];
      btn_act   = lvl[1];
      btn_spd   = lvl[2];
      reset_n   = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/controle_botoes.md
Name: controle_botoes

Overview:
- Input-side counterpart of the 4-digit 7-segment display driver.
- Reads the three raw board pushbuttons (power, action, speed), synchronises and debounces them, and turns each press into a one-cycle event.
- Keeps the registered power, action and speed state: `onoff`, `A_act`/`B_act`/`C_act`, `A_spd`/`B_spd`.
- Generates the digit-multiplex select that the display uses as its `clk`/`sel` input.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- SCAN_DIV, 50000, clk cycles per half-period of `scan_sel`.
- ACT_COUNT, 5, number of action codes; legal codes are 0..ACT_COUNT-1, ACT_COUNT ≤ 8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- btn_onoff  input  1  raw power button, active-low (0 = pressed), asynchronous.
- btn_act  input  1  raw action button, active-low, asynchronous.
- btn_spd  input  1  raw speed button, active-low, asynchronous.
- onoff  output  1  power state, 1 = on.
- A_act  output  1  action code bit 2 (MSB).
- B_act  output  1  action code bit 1.
- C_act  output  1  action code bit 0.
- A_spd  output  1  speed code bit 1 (MSB).
- B_spd  output  1  speed code bit 0.
- scan_sel  output  1  digit-multiplex select, fed to the display select input.
- press_evt  output  1  one-cycle pulse on any accepted press, for the sound/LED hook.

Behaviour:
- Reset (`reset_n` = 0 sampled at a clk edge):
  - `onoff` = 0; action code = 0; speed code = 0; `scan_sel` = 0; `press_evt` = 0.
  - Synchroniser stages and debounced stable levels = 1 (released).
  - Debounce counters and scan counter = 0.
  - Reset wins over any simultaneous press; a press in progress during reset is discarded. After release, a button already held low must still meet the full DEBOUNCE_CYCLES before it is accepted.
- Synchronisation: each button passes through 2 flip-flops before use (s1, s2).
- Debounce, per button, independent:
  - Counter increments every cycle in which s2 ≠ stable level.
  - Counter clears to 0 in any cycle where s2 = stable level.
  - When the counter reaches DEBOUNCE_CYCLES-1 and a mismatch is still present, stable ← s2 and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change stable.
- Press event: stable transition 1→0 only. Releases (0→1) produce nothing.
- Latency: raw falling edge held steady → state outputs and `press_evt` change on the edge DEBOUNCE_CYCLES+2 cycles later. All outputs are registered.
- State update on press events, same edge as the stable transition:
  - onoff press: `onoff` toggles. Turning off forces action = 0 and speed = 0.
  - act press while on: action ← action+1, wrapping ACT_COUNT-1 → 0.
  - spd press while on: speed ← speed+1, wrapping 3 → 0.
  - act/spd presses while off: ignored; no state change, `press_evt` still pulses.
- Simultaneous events in one cycle:
  - onoff has priority.
  - onoff press that turns on: act/spd in the same cycle are ignored, codes stay 0.
  - onoff press that turns off: codes clear.
  - act + spd together while on: both advance.
  - `press_evt` is a single 1-cycle pulse regardless of how many buttons fired.
- Held button: exactly one event per press, no auto-repeat.
- Scan divider:
  - Counter runs 0..SCAN_DIV-1 continuously, independent of `onoff`.
  - `scan_sel` toggles on the edge where the counter wraps, giving period 2·SCAN_DIV cycles.
  - First toggle at cycle SCAN_DIV after reset release.
- Action code never leaves 0..ACT_COUNT-1; internal counter width is ceil(log2(DEBOUNCE_CYCLES))+1.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_DIV=3, ACT_COUNT=5):
- Reset: hold `reset_n`=0 for 3 cycles with all buttons low → all outputs 0. After release, `scan_sel` toggles at cycles 3, 6, 9.
- Power on: `btn_onoff` low for 10 cycles → `onoff`=1 exactly 6 cycles after the falling edge, `press_evt` high for 1 cycle; release → no further event.
- Action wrap: on, 6 separated act presses → ABC code sequence 1, 2, 3, 4, 0, 1. Speed: 5 presses → 1, 2, 3, 0, 1.
- Glitch rejection: `btn_act` low for 3 cycles then high, repeated 5 times → no code change, `press_evt` stays 0.
- Priority: act=3, spd=2, then `btn_onoff` and `btn_act` fall on the same cycle → `onoff`=0, act=0, spd=0, single `press_evt`. Next act press while off → codes stay 0.
- Mid-debounce reset: `btn_spd` low, assert `reset_n`=0 at cycle 3 for 1 cycle, keep the button low → speed unchanged until 6 cycles after reset release.
